// File: rtl/inst_fetch_if.sv
// Byte-wide memory read bus between the instruction fetch unit (master)
// and the memory controller (slave).
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch with an optional direct-mapped one-word-per-line icache.
// Define ICACHE_EN to build the cache; without it every fetch goes to memory.
module inst_fetch #(
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [31:0]       pc_i,
    input  logic              pc_jump_i,
    input  logic              stall_i,
    inst_fetch_if.master      mem,
    output logic              icache_hit_o,
    output logic              inst_ready_o,
    output logic [31:0]       inst_o,
    output logic [31:0]       inst_pc_o,
    output logic              inst_valid_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [1:0]  cnt;
    logic [31:0] fetch_pc;
    logic [31:0] word_buf;
    logic        hit;
    logic [31:0] hit_data;

`ifdef ICACHE_EN
    localparam int LINES = 1 << INDEX_W;

    logic [31:0]        line_data [LINES];
    logic [TAG_W-1:0]   line_tag  [LINES];
    logic [LINES-1:0]   line_valid;

    logic [INDEX_W-1:0] pc_index;
    logic [TAG_W-1:0]   pc_tag;
    logic [INDEX_W-1:0] fill_index;
    logic [TAG_W-1:0]   fill_tag;
    logic [31:0]        fill_word;
    logic               fill_we;

    assign pc_index   = pc_i[INDEX_W+1:2];
    assign pc_tag     = pc_i[INDEX_W+TAG_W+1:INDEX_W+2];
    assign fill_index = fetch_pc[INDEX_W+1:2];
    assign fill_tag   = fetch_pc[INDEX_W+TAG_W+1:INDEX_W+2];
    assign fill_word  = {mem.mem_data, word_buf[23:0]};

    // The line is written on the edge that accepts the last byte, so the
    // final byte comes straight from the bus rather than from word_buf.
    assign fill_we = rdy && rst && (state == FETCH) && mem.mem_ack &&
                     (cnt == 2'd3) && !pc_jump_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_valid <= '0;
        end else if (fill_we) begin
            line_valid[fill_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            line_data[fill_index] <= fill_word;
            line_tag[fill_index]  <= fill_tag;
        end
    end

    assign hit      = line_valid[pc_index] && (line_tag[pc_index] == pc_tag);
    assign hit_data = line_data[pc_index];
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    assign icache_hit_o = hit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else if (rdy) begin
            state <= next_state;
        end
    end

    // A redirect overrides whatever the current state wanted to do next.
    always_comb begin
        next_state   = state;
        mem.mem_req  = 1'b0;
        mem.mem_addr = '0;
        case (state)
            IDLE: begin
                if (!hit) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = {fetch_pc[31:2], cnt};
                if (mem.mem_ack && (cnt == 2'd3)) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (!stall_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (pc_jump_i) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= 2'd0;
            fetch_pc     <= '0;
            word_buf     <= '0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
            inst_ready_o <= 1'b0;
        end else if (rdy) begin
            inst_ready_o <= 1'b0;
            if (pc_jump_i) begin
                cnt          <= 2'd0;
                inst_valid_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!hit) begin
                            fetch_pc <= pc_i;
                            cnt      <= 2'd0;
                        end
                        if (!stall_i) begin
                            if (hit) begin
                                inst_o       <= hit_data;
                                inst_pc_o    <= pc_i;
                                inst_valid_o <= 1'b1;
                            end else begin
                                inst_valid_o <= 1'b0;
                            end
                        end
                    end
                    FETCH: begin
                        if (mem.mem_ack) begin
                            case (cnt)
                                2'd0:    word_buf[7:0]   <= mem.mem_data;
                                2'd1:    word_buf[15:8]  <= mem.mem_data;
                                2'd2:    word_buf[23:16] <= mem.mem_data;
                                default: word_buf[31:24] <= mem.mem_data;
                            endcase
                            cnt <= cnt + 2'd1;
                        end
                        if (!stall_i) begin
                            inst_valid_o <= 1'b0;
                        end
                    end
                    DONE: begin
                        if (!stall_i) begin
                            inst_o       <= word_buf;
                            inst_pc_o    <= fetch_pc;
                            inst_valid_o <= 1'b1;
                            inst_ready_o <= 1'b1;
                        end
                    end
                    default: begin
                        inst_valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch; expectations adapt to whether
// ICACHE_EN is defined for the build.
module tb_inst_fetch;

`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_i;
    logic        pc_jump_i;
    logic        stall_i;
    logic        icache_hit_o;
    logic        inst_ready_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;

    int total = 0;
    int bad   = 0;

    inst_fetch_if mem_bus ();

    inst_fetch #(
        .INDEX_W(7),
        .TAG_W  (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .pc_i        (pc_i),
        .pc_jump_i   (pc_jump_i),
        .stall_i     (stall_i),
        .mem         (mem_bus.master),
        .icache_hit_o(icache_hit_o),
        .inst_ready_o(inst_ready_o),
        .inst_o      (inst_o),
        .inst_pc_o   (inst_pc_o),
        .inst_valid_o(inst_valid_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        pc_i      = pc;
        pc_jump_i = 1'b1;
        stepClk();
        pc_jump_i = 1'b0;
        #1;
    endtask

    // Memory responder: acks every request, optionally freezing the DUT with
    // rdy low (and a junk byte on the bus) once pause_after bytes are in.
    task automatic serveFill(input logic [31:0] base, input logic [31:0] word, input int pause_after);
        int  k      = 0;
        int  guard  = 0;
        bit  paused = 1'b0;
        while (k < 4 && guard < 40) begin
            if (k == pause_after && !paused) begin
                rdy              = 1'b0;
                mem_bus.mem_ack  = 1'b1;
                mem_bus.mem_data = 8'hFF;
                for (int p = 0; p < 2; p++) begin
                    stepClk();
                    checkOutput("addr_frozen", mem_bus.mem_addr, base + k);
                end
                rdy              = 1'b1;
                mem_bus.mem_ack  = 1'b0;
                paused           = 1'b1;
                #1;
            end
            if (mem_bus.mem_req) begin
                checkOutput("mem_addr", mem_bus.mem_addr, base + k);
                mem_bus.mem_ack  = 1'b1;
                mem_bus.mem_data = word[8*k +: 8];
                k++;
            end else begin
                mem_bus.mem_ack = 1'b0;
            end
            guard++;
            stepClk();
        end
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = 8'h00;
        if (k < 4) begin
            checkOutput("fill_timeout", k, 4);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] word, input bit want_hit,
                                 input int stall_cycles, input int pause_after);
        bit hit_eff;
        hit_eff = want_hit && CACHE_ON;
        redirect(pc);
        checkOutput("icache_hit", icache_hit_o, hit_eff);
        checkOutput("mem_req_idle", mem_bus.mem_req, 0);
        stepClk();
        checkOutput("valid_after_lookup", inst_valid_o, hit_eff);
        checkOutput("mem_req_after_lookup", mem_bus.mem_req, !hit_eff);
        if (!hit_eff) begin
            serveFill(pc, word, pause_after);
            checkOutput("mem_req_done", mem_bus.mem_req, 0);
            stall_i = 1'b1;
            for (int i = 0; i < stall_cycles; i++) begin
                stepClk();
                checkOutput("ready_stalled", inst_ready_o, 0);
                checkOutput("mem_req_stalled", mem_bus.mem_req, 0);
            end
            stall_i = 1'b0;
            stepClk();
            checkOutput("valid_done", inst_valid_o, 1);
        end
        checkOutput("inst_ready", inst_ready_o, !hit_eff);
        checkOutput("inst", inst_o, word);
        checkOutput("inst_pc", inst_pc_o, pc);
        stepClk();
        checkOutput("ready_pulse_end", inst_ready_o, 0);
    endtask

    initial begin
        rst              = 1'b0;
        rdy              = 1'b1;
        pc_i             = 32'h0;
        pc_jump_i        = 1'b0;
        stall_i          = 1'b0;
        mem_bus.mem_ack  = 1'b0;
        mem_bus.mem_data = 8'h00;

        repeat (3) stepClk();
        checkOutput("rst_mem_req", mem_bus.mem_req, 0);
        checkOutput("rst_mem_addr", mem_bus.mem_addr, 0);
        checkOutput("rst_inst", inst_o, 0);
        checkOutput("rst_inst_pc", inst_pc_o, 0);
        checkOutput("rst_valid", inst_valid_o, 0);
        checkOutput("rst_ready", inst_ready_o, 0);
        checkOutput("rst_hit", icache_hit_o, 0);
        rst = 1'b1;
        #1;

        $display("[TB] cold fetch and refetch of 0x0");
        applyStimulus(32'h0000_0000, 32'h0000_0513, 1'b0, 0, 4);
        applyStimulus(32'h0000_0000, 32'h0000_0513, 1'b1, 0, 4);

        $display("[TB] redirect after two bytes at 0x100");
        redirect(32'h0000_0100);
        stepClk();
        checkOutput("jump_req_before", mem_bus.mem_req, 1);
        for (int i = 0; i < 2; i++) begin
            mem_bus.mem_ack  = 1'b1;
            mem_bus.mem_data = 8'h78 - 8'(i);
            stepClk();
        end
        mem_bus.mem_ack = 1'b0;
        pc_jump_i       = 1'b1;
        stepClk();
        pc_jump_i = 1'b0;
        checkOutput("mem_req_after_jump", mem_bus.mem_req, 0);
        checkOutput("valid_after_jump", inst_valid_o, 0);
        checkOutput("ready_after_jump", inst_ready_o, 0);
        applyStimulus(32'h0000_0100, 32'h1234_5678, 1'b0, 0, 4);

        $display("[TB] alias replacement on line 0");
        applyStimulus(32'h0000_0200, 32'hDEAD_BEEF, 1'b0, 0, 4);
        applyStimulus(32'h0000_0000, 32'h0000_0513, 1'b0, 0, 4);
        applyStimulus(32'h0000_0000, 32'h0000_0513, 1'b1, 0, 4);

        $display("[TB] stall held in DONE");
        applyStimulus(32'h0000_0300, 32'hCAFE_F00D, 1'b0, 3, 4);

        $display("[TB] rdy low mid-fill");
        applyStimulus(32'h0000_0400, 32'h0BAD_C0DE, 1'b0, 0, 1);

        $display("[TB] reset during fill");
        redirect(32'h0000_0500);
        stepClk();
        mem_bus.mem_ack  = 1'b1;
        mem_bus.mem_data = 8'h11;
        stepClk();
        mem_bus.mem_ack = 1'b0;
        rst             = 1'b0;
        rdy             = 1'b0;
        stepClk();
        checkOutput("midrst_mem_req", mem_bus.mem_req, 0);
        checkOutput("midrst_mem_addr", mem_bus.mem_addr, 0);
        checkOutput("midrst_inst", inst_o, 0);
        checkOutput("midrst_valid", inst_valid_o, 0);
        rst = 1'b1;
        rdy = 1'b1;
        #1;
        applyStimulus(32'h0000_0400, 32'h0BAD_C0DE, 1'b0, 0, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
